ir_fetch_stage: RTL and testbench

Instruction-register stage sitting directly downstream of the instruction memory in the multicycle datapath. On a load strobe from the control unit it waits out the memory's read latency, captures the memory data word together with the PC that addressed it, and decodes the MIPS-style fields. It then presents the result to the decode/register-file stage through a valid/ready handshake, and keeps a retired-instruction counter plus a sticky overrun flag.

---
 rtl/ir_fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_ir_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_stage.sv
// ---------------------------------------------------------------------------
// ir_fetch_stage
//
// Instruction-register stage sitting directly behind the instruction memory
// of the multicycle datapath. A fetch request (ir_write) captures the PC,
// waits out the memory read latency, then registers the memory word and its
// decoded MIPS fields. The result is offered downstream with valid/ready.
// A retired-instruction counter and a sticky overrun flag are also kept.
//
// Parameters
//   MEM_LATENCY  cycles from accepted ir_write to mem_data valid (1..7)
//   COUNT_W      width of instr_count
//
// Ports
//   clk, reset     single clock, synchronous active-high reset
//   ir_write       fetch request (PC presented to memory this cycle)
//   pc             PC captured with an accepted request
//   mem_data       memory data-out word
//   ready          downstream accepts the held instruction
//   valid          instr/pc_tag/fields are valid and held
//   instr, pc_tag  captured word and its PC
//   opcode..jaddr  registered decode of instr
//   busy           a new request would be dropped this cycle
//   overrun        sticky: a request was dropped
//   instr_count    completed handshakes, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module ir_fetch_stage #(
    parameter int MEM_LATENCY = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ir_write,
    input  logic [31:0]        pc,
    input  logic [31:0]        mem_data,
    input  logic               ready,
    output logic               valid,
    output logic [31:0]        instr,
    output logic [31:0]        pc_tag,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [31:0]        imm_sext,
    output logic [25:0]        jaddr,
    output logic               busy,
    output logic               overrun,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // Countdown reload: a value of zero means mem_data is sampled on the
    // very next edge, so MEM_LATENCY=1 loads 0.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q,    state_d;
    logic [2:0]         lat_q,      lat_d;
    logic [31:0]        instr_q,    instr_d;
    logic [31:0]        pc_tag_q,   pc_tag_d;
    logic [5:0]         opcode_q,   opcode_d;
    logic [4:0]         rs_q,       rs_d;
    logic [4:0]         rt_q,       rt_d;
    logic [4:0]         rd_q,       rd_d;
    logic [4:0]         shamt_q,    shamt_d;
    logic [5:0]         funct_q,    funct_d;
    logic [31:0]        imm_sext_q, imm_sext_d;
    logic [25:0]        jaddr_q,    jaddr_d;
    logic               overrun_q,  overrun_d;
    logic [COUNT_W-1:0] count_q,    count_d;

    logic handshake;
    logic accept;
    logic drop;

    // A request in FULL is only taken when the held word leaves in the
    // same cycle; anywhere else outside IDLE it is dropped.
    assign handshake = (state_q == ST_FULL) && ready;
    assign accept    = ir_write && ((state_q == ST_IDLE) || handshake);
    assign drop      = ir_write && !accept;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        instr_d    = instr_q;
        pc_tag_d   = pc_tag_q;
        opcode_d   = opcode_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        shamt_d    = shamt_q;
        funct_d    = funct_q;
        imm_sext_d = imm_sext_q;
        jaddr_d    = jaddr_q;
        count_d    = count_q;
        overrun_d  = overrun_q | drop;

        if (accept) begin
            pc_tag_d = pc;
            lat_d    = LAT_LOAD;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q != 3'd0) begin
                    lat_d = lat_q - 3'd1;
                end else begin
                    // Fields are decoded from the same word that lands in
                    // instr, so they can never disagree with it.
                    instr_d    = mem_data;
                    opcode_d   = mem_data[31:26];
                    rs_d       = mem_data[25:21];
                    rt_d       = mem_data[20:16];
                    rd_d       = mem_data[15:11];
                    shamt_d    = mem_data[10:6];
                    funct_d    = mem_data[5:0];
                    imm_sext_d = {{16{mem_data[15]}}, mem_data[15:0]};
                    jaddr_d    = mem_data[25:0];
                    state_d    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (handshake) begin
                    count_d = count_q + COUNT_ONE;
                    state_d = accept ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lat_q      <= 3'd0;
            instr_q    <= 32'd0;
            pc_tag_q   <= 32'd0;
            opcode_q   <= 6'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            shamt_q    <= 5'd0;
            funct_q    <= 6'd0;
            imm_sext_q <= 32'd0;
            jaddr_q    <= 26'd0;
            overrun_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            instr_q    <= instr_d;
            pc_tag_q   <= pc_tag_d;
            opcode_q   <= opcode_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            shamt_q    <= shamt_d;
            funct_q    <= funct_d;
            imm_sext_q <= imm_sext_d;
            jaddr_q    <= jaddr_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
        end
    end

    assign valid       = (state_q == ST_FULL);
    assign busy        = (state_q == ST_WAIT) || ((state_q == ST_FULL) && !ready);
    assign instr       = instr_q;
    assign pc_tag      = pc_tag_q;
    assign opcode      = opcode_q;
    assign rs          = rs_q;
    assign rt          = rt_q;
    assign rd          = rd_q;
    assign shamt       = shamt_q;
    assign funct       = funct_q;
    assign imm_sext    = imm_sext_q;
    assign jaddr       = jaddr_q;
    assign overrun     = overrun_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_ir_fetch_stage.sv
module tb_ir_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          hold;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [25:0] ja;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MEM_LATENCY=1, COUNT_W=16
    logic        reset, ir_write, ready;
    logic [31:0] pc, mem_data;
    logic        valid, busy, overrun;
    logic [31:0] instr, pc_tag, imm_sext;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [25:0] jaddr;
    logic [15:0] instr_count;

    // Instance B: MEM_LATENCY=3, COUNT_W=4
    logic        b_reset, b_ir_write, b_ready;
    logic [31:0] b_pc, b_mem_data;
    logic        b_valid, b_busy, b_overrun;
    logic [31:0] b_instr, b_pc_tag, b_imm_sext;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
    logic [25:0] b_jaddr;
    logic [3:0]  b_instr_count;

    ir_fetch_stage #(.MEM_LATENCY(1), .COUNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .ir_write(ir_write), .pc(pc),
        .mem_data(mem_data), .ready(ready), .valid(valid), .instr(instr),
        .pc_tag(pc_tag), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm_sext(imm_sext), .jaddr(jaddr),
        .busy(busy), .overrun(overrun), .instr_count(instr_count)
    );

    ir_fetch_stage #(.MEM_LATENCY(3), .COUNT_W(4)) dut_b (
        .clk(clk), .reset(b_reset), .ir_write(b_ir_write), .pc(b_pc),
        .mem_data(b_mem_data), .ready(b_ready), .valid(b_valid), .instr(b_instr),
        .pc_tag(b_pc_tag), .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd),
        .shamt(b_shamt), .funct(b_funct), .imm_sext(b_imm_sext), .jaddr(b_jaddr),
        .busy(b_busy), .overrun(b_overrun), .instr_count(b_instr_count)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_exp = 0;
    int   b_cnt   = 0;
    vec_t vecs[5];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_fields();
        vec_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q[0];
            chk("instr",    instr,    e.word);
            chk("pc_tag",   pc_tag,   e.pc);
            chk("opcode",   32'(opcode), 32'(e.op));
            chk("rs",       32'(rs),     32'(e.rs));
            chk("rt",       32'(rt),     32'(e.rt));
            chk("rd",       32'(rd),     32'(e.rd));
            chk("shamt",    32'(shamt),  32'(e.sh));
            chk("funct",    32'(funct),  32'(e.fn));
            chk("imm_sext", imm_sext,    e.imm);
            chk("jaddr",    32'(jaddr),  32'(e.ja));
        end
    endtask

    // One fetch on instance A: request, one latency cycle, hold, handshake.
    task automatic fetch_a(input vec_t v);
        @(negedge clk);
        ir_write = 1'b1; pc = v.pc; mem_data = 32'hDEAD_BEEF; ready = 1'b0;
        exp_q.push_back(v);
        @(negedge clk);
        ir_write = 1'b0; mem_data = v.word;
        chk("valid_in_wait", 32'(valid), 32'd0);
        chk("busy_in_wait",  32'(busy),  32'd1);
        @(negedge clk);
        mem_data = 32'hDEAD_BEEF;
        chk("valid_rise", 32'(valid), 32'd1);
        check_fields();
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("valid_hold", 32'(valid), 32'd1);
            chk("instr_hold", instr, v.word);
            chk("busy_hold",  32'(busy),  32'd1);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        cnt_exp++;
        chk("count_after_hs", 32'(instr_count), 32'(cnt_exp & 16'hFFFF));
        chk("valid_after_hs", 32'(valid), 32'd0);
        void'(exp_q.pop_front());
        $display("[TB] A txn pc=0x%08h word=0x%08h count=%0d", v.pc, v.word, instr_count);
    endtask

    // One fetch on instance B (latency 3) with immediate handshake.
    task automatic fetch_b(input logic [31:0] p, input logic [31:0] w);
        @(negedge clk);
        b_ir_write = 1'b1; b_pc = p; b_mem_data = 32'hDEAD_BEEF; b_ready = 1'b0;
        @(negedge clk);
        b_ir_write = 1'b0;
        chk("b_valid_e0", 32'(b_valid), 32'd0);
        @(negedge clk);
        chk("b_valid_e1", 32'(b_valid), 32'd0);
        @(negedge clk);
        b_mem_data = w;
        chk("b_valid_e2", 32'(b_valid), 32'd0);
        @(negedge clk);
        b_mem_data = 32'hDEAD_BEEF;
        chk("b_valid_e3", 32'(b_valid), 32'd1);
        chk("b_instr",    b_instr, w);
        chk("b_pc_tag",   b_pc_tag, p);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        b_cnt++;
        chk("b_count", 32'(b_instr_count), 32'(b_cnt % 16));
        $display("[TB] B txn pc=0x%08h word=0x%08h count=%0d", p, w, b_instr_count);
    endtask

    initial begin
        vecs[0] = '{32'h0,  32'h8C220004, 0, 6'h23, 5'd1,  5'd2,  5'd0,  5'd0,  6'h04, 32'h00000004, 26'h0220004};
        vecs[1] = '{32'h4,  32'h2001FFFC, 5, 6'h08, 5'd0,  5'd1,  5'd31, 5'd31, 6'h3C, 32'hFFFFFFFC, 26'h001FFFC};
        vecs[2] = '{32'h8,  32'h012A4020, 1, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 26'h12A4020};
        vecs[3] = '{32'hC,  32'h08000010, 2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h10, 32'h00000010, 26'h0000010};
        vecs[4] = '{32'h10, 32'hFFFF8000, 0, 6'h3F, 5'd31, 5'd31, 5'd16, 5'd0,  6'h00, 32'hFFFF8000, 26'h3FF8000};

        reset = 1'b1; ir_write = 1'b0; ready = 1'b0; pc = 32'd0; mem_data = 32'd0;
        b_reset = 1'b1; b_ir_write = 1'b0; b_ready = 1'b0; b_pc = 32'd0; b_mem_data = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; b_reset = 1'b0;
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_count",   32'(instr_count), 32'd0);
        chk("rst_instr",   instr,  32'd0);
        chk("rst_pc_tag",  pc_tag, 32'd0);
        chk("rst_opcode",  32'(opcode), 32'd0);
        chk("rst_imm",     imm_sext, 32'd0);

        // Table-driven fetches on instance A.
        for (int i = 0; i < 5; i++) fetch_a(vecs[i]);
        chk("no_overrun_yet", 32'(overrun), 32'd0);

        // Dropped requests in WAIT and in FULL without ready.
        @(negedge clk);
        ir_write = 1'b1; pc = 32'h40; mem_data = 32'hDEAD_BEEF; ready = 1'b0;
        @(negedge clk);
        chk("drop_busy_wait", 32'(busy), 32'd1);
        ir_write = 1'b1; pc = 32'h99; mem_data = 32'h012A4020;
        @(negedge clk);
        ir_write = 1'b1; pc = 32'h77; mem_data = 32'hDEAD_BEEF;
        chk("drop_overrun", 32'(overrun), 32'd1);
        chk("drop_valid",   32'(valid),   32'd1);
        chk("drop_instr",   instr,  32'h012A4020);
        chk("drop_pc_tag",  pc_tag, 32'h40);
        chk("drop_busy_full", 32'(busy), 32'd1);
        @(negedge clk);
        ir_write = 1'b0;
        chk("drop2_instr",  instr,  32'h012A4020);
        chk("drop2_pc_tag", pc_tag, 32'h40);
        chk("drop2_valid",  32'(valid), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        cnt_exp++;
        chk("drop_count", 32'(instr_count), 32'(cnt_exp));
        chk("drop_valid_low", 32'(valid), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        $display("[TB] A txn pc=0x00000040 word=0x012a4020 with dropped requests");

        // Handshake and new accept in the same cycle.
        @(negedge clk);
        ir_write = 1'b1; pc = 32'h4; mem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ir_write = 1'b0; mem_data = 32'h8C220004;
        @(negedge clk);
        mem_data = 32'hDEAD_BEEF;
        chk("sim_valid", 32'(valid), 32'd1);
        ready = 1'b1; ir_write = 1'b1; pc = 32'h8;
        #1;
        chk("sim_busy_ready", 32'(busy), 32'd0);
        @(negedge clk);
        ready = 1'b0; ir_write = 1'b0; mem_data = 32'h2001FFFC;
        cnt_exp++;
        chk("sim_count",  32'(instr_count), 32'(cnt_exp));
        chk("sim_valid_low", 32'(valid), 32'd0);
        chk("sim_pc_tag", pc_tag, 32'h8);
        chk("sim_busy_wait", 32'(busy), 32'd1);
        @(negedge clk);
        mem_data = 32'hDEAD_BEEF;
        chk("sim_valid2", 32'(valid), 32'd1);
        chk("sim_instr2", instr, 32'h2001FFFC);
        chk("sim_imm2",   imm_sext, 32'hFFFFFFFC);
        $display("[TB] A txn back-to-back pc=0x00000008 word=0x2001fffc");

        // Reset wins over ready and ir_write while FULL.
        reset = 1'b1; ready = 1'b1; ir_write = 1'b1; pc = 32'h55;
        @(negedge clk);
        reset = 1'b0; ready = 1'b0; ir_write = 1'b0;
        cnt_exp = 0;
        chk("rstp_valid",   32'(valid), 32'd0);
        chk("rstp_count",   32'(instr_count), 32'd0);
        chk("rstp_pc_tag",  pc_tag, 32'd0);
        chk("rstp_instr",   instr, 32'd0);
        chk("rstp_overrun", 32'(overrun), 32'd0);
        chk("rstp_busy",    32'(busy), 32'd0);

        // Instance B: reset one cycle after a request discards it.
        @(negedge clk);
        b_ir_write = 1'b1; b_pc = 32'h200; b_mem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        b_ir_write = 1'b0; b_reset = 1'b1;
        @(negedge clk);
        b_reset = 1'b0; b_mem_data = 32'h8C220004;
        chk("b_rst_valid", 32'(b_valid), 32'd0);
        chk("b_rst_busy",  32'(b_busy),  32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_rst_late_valid", 32'(b_valid), 32'd0);
            chk("b_rst_late_instr", b_instr, 32'd0);
            chk("b_rst_late_count", 32'(b_instr_count), 32'd0);
        end
        b_mem_data = 32'hDEAD_BEEF;
        $display("[TB] B txn pc=0x00000200 discarded by reset");

        // Instance B: 17 fetches, counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            fetch_b(32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i * 32'h0001_0101));
        end
        chk("b_wrap_count", 32'(b_instr_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
